// File: rtl/signed_addsub32.sv
// signed_addsub32: registered 32-bit add/sub slice with carry/borrow-in and status flags.
// Optional `SATURATE_EN clamps z to the signed limit on overflow instead of wrapping.
module signed_addsub32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  sel,
    input  logic        cin,
    input  logic        bin,
    output logic        cout,
    output logic        bout,
    output logic [31:0] z,
    output logic        carry,
    output logic        zero,
    output logic        overflow,
    output logic        negative
);

    logic        add_op;
    logic        sub_op;
    logic [31:0] b_eff;
    logic [32:0] cc;
    logic [31:0] sum;
    logic        ovf_next;
    logic        cout_next;
    logic        bout_next;
    logic [31:0] z_next;

    // Opcode decode: only 01 and 10 update the registers
    always_comb begin
        add_op = (sel == 2'b01);
        sub_op = (sel == 2'b10);
    end

    // Ripple chain of full adders; subtraction feeds ~b and ~bin
    always_comb begin
        b_eff = sub_op ? ~b : b;
        sum   = '0;
        cc    = '0;
        cc[0] = sub_op ? ~bin : cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = a[i] ^ b_eff[i] ^ cc[i];
            cc[i+1]  = (a[i] & b_eff[i]) | (cc[i] & (a[i] ^ b_eff[i]));
        end
    end

    // Next-state flags and result; overflow uses the effective operand sign
    always_comb begin
        cout_next = add_op & cc[32];
        bout_next = sub_op & ~cc[32];
        ovf_next  = (a[31] == b_eff[31]) && (sum[31] != a[31]);
`ifdef SATURATE_EN
        if (ovf_next)
            z_next = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            z_next = sum;
`else
        z_next = sum;
`endif
    end

    // Output registers: reset clears, add/sub loads, other opcodes hold
    always_ff @(posedge clk) begin
        if (rst) begin
            z        <= '0;
            cout     <= 1'b0;
            bout     <= 1'b0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else if (add_op || sub_op) begin
            z        <= z_next;
            cout     <= cout_next;
            bout     <= bout_next;
            carry    <= cout_next | bout_next;
            zero     <= (z_next == 32'h0);
            overflow <= ovf_next;
            negative <= z_next[31];
        end
    end

endmodule

// File: tb/tb_signed_addsub32.sv
// tb_signed_addsub32: scoreboard bench with a signed-arithmetic reference model.
// Build with +define+SATURATE_EN to check the clamping variant.
module tb_signed_addsub32;

    typedef struct packed {
        logic [31:0] z;
        logic        cout;
        logic        bout;
        logic        carry;
        logic        zero;
        logic        ovf;
        logic        neg;
    } exp_t;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  sel = 2'b00;
    logic        cin = 1'b0;
    logic        bin = 1'b0;
    logic        cout, bout, carry, zero, overflow, negative;
    logic [31:0] z;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t mstate = '0;

    signed_addsub32 dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
        .cin(cin), .bin(bin), .cout(cout), .bout(bout), .z(z),
        .carry(carry), .zero(zero), .overflow(overflow),
        .negative(negative)
    );

    always #5 clk = ~clk;

    // Reference: exact signed result decides overflow; unsigned 33-bit decides carry/borrow
    function automatic exp_t model(exp_t prev, logic r, logic [1:0] s,
                                   logic [31:0] x, logic [31:0] y,
                                   logic ci, logic bi);
        exp_t   n;
        longint sx, sy, t, lc, lb;
        logic [32:0] w;
        if (r) return '0;
        if (s != 2'b01 && s != 2'b10) return prev;
        sx = $signed(x);
        sy = $signed(y);
        lc = longint'(ci);
        lb = longint'(bi);
        n  = '0;
        if (s == 2'b01) begin
            w      = {1'b0, x} + {1'b0, y} + {32'b0, ci};
            t      = sx + sy + lc;
            n.cout = w[32];
            n.bout = 1'b0;
        end else begin
            w      = {1'b0, x} - {1'b0, y} - {32'b0, bi};
            t      = sx - sy - lb;
            n.cout = 1'b0;
            n.bout = ({1'b0, x} < ({1'b0, y} + {32'b0, bi}));
        end
        n.carry = n.cout | n.bout;
        n.ovf   = (t > MAXS) || (t < MINS);
        n.z     = w[31:0];
`ifdef SATURATE_EN
        if (n.ovf) n.z = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        n.zero = (n.z == 32'h0);
        n.neg  = n.z[31];
        return n;
    endfunction

    task automatic issue(input logic r, input logic [1:0] s,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic bi);
        @(negedge clk);
        rst = r; sel = s; a = x; b = y; cin = ci; bin = bi;
        mstate = model(mstate, r, s, x, y, ci, bi);
        sb_q.push_back(mstate);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Monitor: outputs are valid every cycle; pop and compare after each edge
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                g = '{z, cout, bout, carry, zero, overflow, negative};
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got z=%h co=%b bo=%b c=%b zr=%b ov=%b n=%b exp z=%h co=%b bo=%b c=%b zr=%b ov=%b n=%b",
                             $time, g.z, g.cout, g.bout, g.carry, g.zero, g.ovf, g.neg,
                             e.z, e.cout, e.bout, e.carry, e.zero, e.ovf, e.neg);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] s;
        issue(1, 2'b01, 32'd5, 32'd3, 0, 0);
        issue(0, 2'b01, 32'd5, 32'd3, 0, 0);
        issue(0, 2'b01, 32'h7FFF_FFFF, 32'd1, 0, 0);
        issue(0, 2'b01, 32'hFFFF_FFFF, 32'd0, 1, 0);
        for (int i = 0; i < 3; i++)
            issue(0, (i % 2 == 0) ? 2'b00 : 2'b11, $urandom, $urandom,
                  1'($urandom), 1'($urandom));
        issue(0, 2'b10, 32'd5, 32'd7, 0, 0);
        issue(0, 2'b10, 32'd5, 32'd7, 1, 1);
        issue(0, 2'b10, 32'h8000_0000, 32'd1, 0, 1);
        issue(0, 2'b10, 32'd9, 32'd9, 1, 0);
        issue(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1);
        issue(1, 2'b10, 32'd1, 32'd2, 0, 0);
        issue(0, 2'b11, 32'd1, 32'd2, 1, 1);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 9) == 0)
                s = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            else
                s = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            issue(0, s, rnd_word(), rnd_word(), 1'($urandom), 1'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_addsub32.md
Name: signed_addsub32

Overview:
32-bit registered adder/subtractor for signed and unsigned operands, with carry-in for addition and borrow-in for subtraction. It produces a result word, a carry/borrow out, and a four-flag status set: carry, zero, overflow and negative. It is a leaf datapath block, intended as the ALU add/sub slice. Operation is selected per cycle by a 2-bit opcode.

Parameters:
- none. Width is fixed at 32 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  32  operand A (two's complement or unsigned)
- b  input  32  operand B
- sel  input  2  opcode: 2'b01 = add, 2'b10 = subtract, 2'b00/2'b11 = hold
- cin  input  1  carry-in; used only when sel=01
- bin  input  1  borrow-in; used only when sel=10
- cout  output  1  unsigned carry-out of the addition
- bout  output  1  unsigned borrow-out of the subtraction
- z  output  32  result
- carry  output  1  carry flag
- zero  output  1  high when z == 0
- overflow  output  1  signed two's-complement overflow
- negative  output  1  equals z[31]

Behaviour:
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. There is no handshake, and a new operation can be issued every cycle.
- Reset: when rst=1 at a rising edge, z, cout, bout, carry, zero, overflow and negative all become 0, even though z=0. rst takes priority over sel.
- sel=01 (add): {cout, z} = a + b + cin, computed as a 33-bit sum. bout=0. carry=cout. overflow = (a[31]==b[31]) && (sum[31]!=a[31]).
- sel=10 (subtract): z = a - b - bin, mod 2^32. bout=1 when a < b + bin, compared as unsigned 33-bit values. cout=0. carry=bout. overflow = (a[31]!=b[31]) && (diff[31]!=a[31]).
- sel=00 or 11: all output registers hold their previous values. cin and bin are ignored.
- zero = (z_next == 32'h0). negative = z_next[31]. Both are derived from the value being registered, so they are coherent with z in the same cycle.
- cin is ignored in subtract mode, and bin is ignored in add mode.
- Wrap-around: results wrap modulo 2^32. Signed overflow affects only the overflow flag, except as described under Optional Feature.
- Structure: a ripple chain of 32 full-adder cells. B is inverted and the carry-in is driven as ~bin for subtraction. Borrow-out = ~carry-out of that chain. Synthesis-inferred "+" is also acceptable, provided results are bit-exact.

Optional Feature:
- Macro: SATURATE_EN.
- Defined: when overflow=1, z clamps to the signed limit instead of wrapping.
  - Positive overflow (a[31]=0) gives 32'h7FFFFFFF.
  - Negative overflow (a[31]=1) gives 32'h80000000.
  - overflow still reads 1.
  - zero and negative are computed from the clamped z.
  - cout, bout and carry are unaffected.
- Not defined: pure modulo-2^32 wrap, as specified in Behaviour.

Test Plan:
- Reset: rst=1 with sel=01, a=5, b=3 -> after the edge, all outputs are 0. Deassert rst -> the next edge gives z=8.
- Add with signed overflow: sel=01, a=32'h7FFFFFFF, b=1, cin=0 -> z=32'h80000000, overflow=1, negative=1, cout=0, carry=0, zero=0. With SATURATE_EN: z=32'h7FFFFFFF, negative=0.
- Add with unsigned carry: sel=01, a=32'hFFFFFFFF, b=0, cin=1 -> z=0, cout=1, carry=1, zero=1, overflow=0, bout=0.
- Subtract with borrow: sel=10, a=5, b=7, bin=0 -> z=32'hFFFFFFFE, bout=1, carry=1, negative=1, overflow=0, cout=0. With bin=1 and cin=1 (cin ignored) -> z=32'hFFFFFFFD.
- Subtract with signed overflow: sel=10, a=32'h80000000, b=1, bin=1 -> z=32'h7FFFFFFE, overflow=1, bout=0, negative=0. With SATURATE_EN: z=32'h80000000.
- Hold: after the add above, set sel=00 and sel=11 with random a, b, cin, bin for 3 cycles -> all outputs stay unchanged. Random regression: 1000 cycles of random sel=01/10 checked against a 33-bit reference model.
